// File: rtl/booth_sequencer.sv
// Control FSM for a radix-2 Booth multiplier: sequences load, add/subtract
// and shift commands to the multiplier and accumulator registers.
module booth_sequencer #(
    parameter int N  = 4,
    parameter int CW = $clog2(N+1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic x0,
    output logic ldx,
    output logic ldy,
    output logic clra,
    output logic lda,
    output logic sub,
    output logic shrx,
    output logic shra,
    output logic busy,
    output logic done,
    output logic q_prev
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] C_N   = CW'(N);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_count;
    logic          r_q_prev;
    logic          r_sub;
    logic [1:0]    w_pair;

    assign w_pair = {x0, r_q_prev};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_q_prev <= 1'b0;
            r_sub    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) r_state <= S_LOAD;
                S_LOAD: begin
                    r_q_prev <= 1'b0;
                    r_count  <= C_N;
                    r_state  <= S_EVAL;
                end
                S_EVAL: begin
                    // 01 -> add multiplicand, 10 -> subtract, 00/11 -> shift only
                    case (w_pair)
                        2'b01: begin r_sub <= 1'b0; r_state <= S_ADD; end
                        2'b10: begin r_sub <= 1'b1; r_state <= S_ADD; end
                        default: r_state <= S_SHIFT;
                    endcase
                end
                S_ADD: r_state <= S_SHIFT;
                S_SHIFT: begin
                    r_q_prev <= x0;
                    r_count  <= r_count - C_ONE;
                    r_state  <= (r_count == C_ONE) ? S_DONE : S_EVAL;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from registered state only
    assign ldx    = (r_state == S_LOAD);
    assign ldy    = (r_state == S_LOAD);
    assign clra   = (r_state == S_LOAD);
    assign lda    = (r_state == S_ADD);
    assign sub    = (r_state == S_ADD) && r_sub;
    assign shrx   = (r_state == S_SHIFT);
    assign shra   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);
    assign busy   = (r_state != S_IDLE);
    assign q_prev = r_q_prev;

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: models the multiplier/accumulator datapath and
// checks command sequences, timing and the resulting product.
module tb_booth_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst, start, x0;
    logic ldx, ldy, clra, lda, sub, shrx, shra, busy, done, q_prev;

    always #5 clk = ~clk;

    booth_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0),
        .ldx(ldx), .ldy(ldy), .clra(clra), .lda(lda), .sub(sub),
        .shrx(shrx), .shra(shra), .busy(busy), .done(done), .q_prev(q_prev)
    );

    int n_vec = 0;
    int n_err = 0;

    // datapath model: X multiplier shift reg, Y multiplicand, A accumulator (one guard bit)
    logic [N-1:0] X = '0, Xn = '0, Y = '0, Yn = '0, xin = '0, yin = '0;
    logic [N:0]   A = '0, An = '0;
    int n_shrx, n_shra, n_ldx, n_done, inv_err = 0;
    bit obs_sub[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_shrx = 0; n_shra = 0; n_ldx = 0; n_done = 0;
        obs_sub.delete();
    endtask

    // one clock: commit the register updates of the edge, then sample the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        X = Xn; A = An; Y = Yn;
        x0 = X[0];
        Xn = X; An = A; Yn = Y;
        if (ldx)  Xn = xin;
        if (ldy)  Yn = yin;
        if (clra) An = '0;
        if (lda)  An = sub ? A - {Y[N-1], Y} : A + {Y[N-1], Y};
        if (shrx) Xn = {A[0], X[N-1:1]};
        if (shra) An = {A[N], A[N:1]};
        if (lda && shrx) inv_err++;
        if ((ldx | ldy | clra) && !(ldx & ldy & clra)) inv_err++;
        if (shrx) n_shrx++;
        if (shra) n_shra++;
        if (ldx)  n_ldx++;
        if (done) n_done++;
        if (lda)  obs_sub.push_back(sub);
    endtask

    function automatic int pack(input bit q[$]);
        int v = 1;
        foreach (q[i]) v = v * 2 + int'(q[i]);
        return v;
    endfunction

    task automatic run_job(input logic [N-1:0] x, input logic [N-1:0] y,
                           input bit noise, input bit hold);
        bit es[$];
        bit prev;
        int k;
        bit seen;
        logic signed [N-1:0] sx, sy;
        int p;
        // reference: Booth recoding of x straight from the bit pairs
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (x[i] && !prev) es.push_back(1'b1);
            if (!x[i] && prev) es.push_back(1'b0);
            prev = x[i];
        end
        sx = x; sy = y;
        p = int'(sx) * int'(sy);
        xin = x; yin = y;
        clear_counts();
        start = 1'b1;
        tick();
        for (int j = 0; j < (hold ? 2 : 1); j++) begin
            chk("load_ldx", {31'd0, ldx}, 1);
            start = hold && (j == 0);
            k = 1;
            seen = 1'b0;
            while (!seen && k < 60) begin
                if (noise) start = 1'($urandom_range(0, 1));
                tick();
                k++;
                if (done) seen = 1'b1;
            end
            chk("done_cycle", seen ? k : 0, 2 + 2 * N + es.size());
            chk("busy_at_done", {31'd0, busy}, 1);
            chk("qprev_last", {31'd0, q_prev}, {31'd0, x[N-1]});
            chk("shrx_cnt", n_shrx, N);
            chk("shra_cnt", n_shra, N);
            chk("ldx_cnt", n_ldx, 1);
            chk("sub_seq", pack(obs_sub), pack(es));
            chk("product", {24'd0, A[N-1:0], X}, {24'd0, p[2*N-1:0]});
            chk("invariants", inv_err, 0);
            if (hold && j == 0) begin
                tick();
                chk("b2b_idle", {31'd0, busy}, 0);
                clear_counts();
                tick();
            end
        end
        start = 1'b0;
        tick();
        chk("post_idle", {31'd0, busy}, 0);
    endtask

    initial begin
        int nadd;
        rst = 1'b1; start = 1'b0; x0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            chk("idle_outs", {21'd0, ldx, ldy, clra, lda, sub, shrx, shra, busy, done, q_prev}, 0);
        end

        run_job(4'b0000, 4'b0011, 1'b0, 1'b0);
        run_job(4'b1001, 4'b0011, 1'b0, 1'b0);
        run_job(4'b0101, 4'b0110, 1'b0, 1'b0);

        // reset during the second ADD cycle of a 0101 job
        xin = 4'b0101; yin = 4'b0011;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        nadd = 0;
        for (int i = 0; i < 40 && nadd < 2; i++) begin
            tick();
            if (lda) nadd++;
        end
        chk("rst_second_add", nadd, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_outs", {21'd0, ldx, ldy, clra, lda, sub, shrx, shra, busy, done, q_prev}, 0);
        clear_counts();
        repeat (6) tick();
        chk("rst_no_done", n_done, 0);
        chk("rst_stay_idle", {31'd0, busy}, 0);
        run_job(4'b0101, 4'b0011, 1'b0, 1'b0);

        run_job(4'b1011, 4'b1101, 1'b0, 1'b1);

        for (int r = 0; r < 16; r++)
            run_job(4'($urandom), 4'($urandom), 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
